// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between a client and the PS/2 host transmitter.
// The client offers a byte with valid/ready and later sees one done pulse carrying the ack/error status.
interface ps2_host_tx_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_busy;
    logic       o_done;
    logic       o_ack_ok;
    logic       o_error;

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_busy,
        output o_done,
        output o_ack_ok,
        output o_error
    );

    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_busy,
        input  o_done,
        input  o_ack_ok,
        input  o_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits LSB first, odd parity and stop,
// then check the device ACK. Both PS/2 lines are open-drain, driven low only through the *_oe outputs.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000,
    parameter int FILTER_LEN     = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ps2_host_tx_if.slave  ctrl,
    input  logic          i_ps2_clk,
    input  logic          i_ps2_dat,
    output logic          o_ps2_clk_oe,
    output logic          o_ps2_dat_oe
);

    localparam int TIMER_MAX0 = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int TIMER_MAX  = (TIMER_MAX0 > XFER_TIMEOUT) ? TIMER_MAX0 : XFER_TIMEOUT;
    localparam int TIMER_W    = $clog2(TIMER_MAX + 1);
    localparam int FILT_W     = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        SHIFT,
        ACKWAIT,
        DONE,
        FAIL
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic                r_clkMeta;
    logic                r_clkSync;
    logic                r_datMeta;
    logic                r_datSync;
    logic                r_clkFilt;
    logic                r_clkFiltD;
    logic [FILT_W-1:0]   r_filtCnt;
    logic [TIMER_W-1:0]  r_timer;
    logic [TIMER_W-1:0]  w_timerNext;
    logic [3:0]          r_bitCnt;
    logic [3:0]          w_bitCntNext;
    logic [7:0]          r_byte;
    logic [7:0]          w_byteNext;
    logic                r_parity;
    logic                w_parityNext;
    logic                r_datOe;
    logic                w_datOeNext;
    logic                w_fall;

    // Lines idle high, so the synchronizers and filter start high to avoid a fake fall out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clkMeta  <= 1'b1;
            r_clkSync  <= 1'b1;
            r_datMeta  <= 1'b1;
            r_datSync  <= 1'b1;
            r_clkFilt  <= 1'b1;
            r_clkFiltD <= 1'b1;
            r_filtCnt  <= '0;
        end else begin
            r_clkMeta  <= i_ps2_clk;
            r_clkSync  <= r_clkMeta;
            r_datMeta  <= i_ps2_dat;
            r_datSync  <= r_datMeta;
            r_clkFiltD <= r_clkFilt;
            if (r_clkSync == r_clkFilt) begin
                r_filtCnt <= '0;
            end else if (r_filtCnt == FILT_W'(FILTER_LEN - 1)) begin
                r_clkFilt <= r_clkSync;
                r_filtCnt <= '0;
            end else begin
                r_filtCnt <= r_filtCnt + FILT_W'(1);
            end
        end
    end

    assign w_fall = r_clkFiltD & ~r_clkFilt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            r_bitCnt <= '0;
            r_byte   <= '0;
            r_parity <= 1'b0;
            r_datOe  <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_timer  <= w_timerNext;
            r_bitCnt <= w_bitCntNext;
            r_byte   <= w_byteNext;
            r_parity <= w_parityNext;
            r_datOe  <= w_datOeNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_timerNext   = r_timer;
        w_bitCntNext  = r_bitCnt;
        w_byteNext    = r_byte;
        w_parityNext  = r_parity;
        w_datOeNext   = r_datOe;
        ctrl.o_ready  = 1'b0;
        ctrl.o_busy   = 1'b1;
        ctrl.o_done   = 1'b0;
        ctrl.o_ack_ok = 1'b0;
        ctrl.o_error  = 1'b0;
        o_ps2_clk_oe  = 1'b0;
        o_ps2_dat_oe  = 1'b0;

        case (r_state)
            IDLE: begin
                ctrl.o_ready = 1'b1;
                ctrl.o_busy  = 1'b0;
                w_datOeNext  = 1'b0;
                if (ctrl.i_valid) begin
                    w_byteNext   = ctrl.i_data;
                    w_parityNext = ~^ctrl.i_data;
                    w_timerNext  = '0;
                    w_stateNext  = INHIBIT;
                end
            end

            INHIBIT: begin
                o_ps2_clk_oe = 1'b1;
                o_ps2_dat_oe = (r_timer >= TIMER_W'(INHIBIT_CYCLES - 10));
                if (r_timer == TIMER_W'(INHIBIT_CYCLES - 1)) begin
                    w_timerNext = '0;
                    w_stateNext = RELEASE;
                end else begin
                    w_timerNext = r_timer + TIMER_W'(1);
                end
            end

            // Start bit is held; the device's first falling edge launches data bit 0.
            RELEASE: begin
                o_ps2_dat_oe = 1'b1;
                if (w_fall) begin
                    w_bitCntNext = 4'd1;
                    w_datOeNext  = ~r_byte[0];
                    w_timerNext  = '0;
                    w_stateNext  = SHIFT;
                end else if (r_timer == TIMER_W'(START_TIMEOUT - 1)) begin
                    w_stateNext = FAIL;
                end else begin
                    w_timerNext = r_timer + TIMER_W'(1);
                end
            end

            SHIFT: begin
                o_ps2_dat_oe = r_datOe;
                w_timerNext  = r_timer + TIMER_W'(1);
                if (w_fall) begin
                    w_bitCntNext = r_bitCnt + 4'd1;
                    if (r_bitCnt <= 4'd7) begin
                        w_datOeNext = ~r_byte[r_bitCnt[2:0]];
                    end else if (r_bitCnt == 4'd8) begin
                        w_datOeNext = ~r_parity;
                    end else if (r_bitCnt == 4'd9) begin
                        w_datOeNext = 1'b0;
                    end else begin
                        w_stateNext = r_datSync ? FAIL : ACKWAIT;
                    end
                end else if (r_timer == TIMER_W'(XFER_TIMEOUT - 1)) begin
                    w_stateNext = FAIL;
                end
            end

            ACKWAIT: begin
                w_timerNext = r_timer + TIMER_W'(1);
                if (r_clkSync && r_datSync) begin
                    w_stateNext = DONE;
                end else if (r_timer == TIMER_W'(XFER_TIMEOUT - 1)) begin
                    w_stateNext = FAIL;
                end
            end

            DONE: begin
                ctrl.o_done   = 1'b1;
                ctrl.o_ack_ok = 1'b1;
                w_stateNext   = IDLE;
            end

            FAIL: begin
                ctrl.o_done  = 1'b1;
                ctrl.o_error = 1'b1;
                w_stateNext  = IDLE;
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks the frame out, captures the DAT bits
// and answers with or without ACK; frames are compared against an arithmetic model of the byte.
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int STO  = 300;
    localparam int XTO  = 1500;
    localparam int FL   = 8;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    logic devClk = 1'b1;
    logic devDat = 1'b1;
    logic clkOe;
    logic datOe;
    logic ps2ClkPin;
    logic ps2DatPin;

    assign ps2ClkPin = clkOe ? 1'b0 : devClk;
    assign ps2DatPin = datOe ? 1'b0 : devDat;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (STO),
        .XFER_TIMEOUT   (XTO),
        .FILTER_LEN     (FL)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .ctrl         (bus.slave),
        .i_ps2_clk    (ps2ClkPin),
        .i_ps2_dat    (ps2DatPin),
        .o_ps2_clk_oe (clkOe),
        .o_ps2_dat_oe (datOe)
    );

    int   total = 0;
    int   bad = 0;
    int   doneCnt = 0;
    int   acceptCnt = 0;
    int   acceptAtDone = 0;
    logic lastAck = 1'b0;
    logic lastErr = 1'b0;

    // Monitor samples 1ns after the falling edge, i.e. what the next rising edge will act on.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (bus.o_done) begin
                doneCnt++;
                lastAck = bus.o_ack_ok;
                lastErr = bus.o_error;
                acceptAtDone = acceptCnt;
            end
            if (bus.i_valid && bus.o_ready) acceptCnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Wire order {stop, parity, d7..d0}; bit i of the byte is (d / 2^i) mod 2, parity makes the ones count odd.
    function automatic logic [9:0] frameOf(input logic [7:0] d);
        logic [9:0] f;
        int v;
        int ones;
        v = int'(d);
        ones = 0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[i] = ((v % 2) == 1);
            ones += v % 2;
            v = v / 2;
        end
        f[8] = ((ones % 2) == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic runDevice(input string tag, input bit giveAck, input int glitchAt, input int abortAt,
                             output logic [9:0] bits, output bit aborted);
        int n;
        int d0;
        bits = '0;
        aborted = 1'b0;
        n = 0;
        while (clkOe && n < INH + 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_release"}, 32'(!clkOe), 32'd1);
        checkOutput({tag, "_rts_start"}, 32'(datOe), 32'd1);
        waitNeg(30);
        for (int k = 1; k <= 11; k++) begin
            if (k == glitchAt) begin
                devClk = 1'b0;
                waitNeg(2);
                devClk = 1'b1;
                waitNeg(8);
            end
            devClk = 1'b0;
            if (k == abortAt) begin
                waitNeg(15);
                d0 = doneCnt;
                rst = 1'b1;
                waitNeg(1);
                checkOutput({tag, "_abort_oe"}, {30'd0, clkOe, datOe}, 32'd0);
                checkOutput({tag, "_abort_ready"}, 32'(bus.o_ready), 32'd1);
                rst = 1'b0;
                devClk = 1'b1;
                waitNeg(60);
                checkOutput({tag, "_abort_no_done"}, 32'(doneCnt - d0), 32'd0);
                aborted = 1'b1;
                return;
            end
            waitNeg(HALF);
            if (k <= 10) bits[k-1] = ps2DatPin;
            devClk = 1'b1;
            if (k == 10 && giveAck) devDat = 1'b0;
            if (k == 11) devDat = 1'b1;
            waitNeg(HALF);
        end
    endtask

    // mode: 0 = device ACKs, 1 = device leaves DAT high, 2 = device never clocks.
    task automatic applyStimulus(input string tag, input logic [7:0] d, input int mode, input int glitchAt,
                                 input logic [9:0] expFrame, input logic expAck, input logic expErr);
        int d0;
        int n;
        logic [9:0] bits;
        bit ab;
        d0 = doneCnt;
        @(negedge clk);
        bus.i_data = d;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_data = ~d;
        checkOutput({tag, "_ready_after_accept"}, 32'(bus.o_ready), 32'd0);
        checkOutput({tag, "_busy_after_accept"}, 32'(bus.o_busy), 32'd1);
        if (mode != 2) begin
            runDevice(tag, (mode == 0), glitchAt, 0, bits, ab);
            checkOutput({tag, "_frame"}, 32'(bits), 32'(expFrame));
        end
        n = 0;
        while (doneCnt == d0 && n < INH + STO + XTO) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done_count"}, 32'(doneCnt - d0), 32'd1);
        checkOutput({tag, "_ack_ok"}, 32'(lastAck), 32'(expAck));
        checkOutput({tag, "_error"}, 32'(lastErr), 32'(expErr));
        if (mode == 2)
            checkOutput({tag, "_timeout_window"}, 32'(n >= INH + STO - 3 && n <= INH + STO + 3), 32'd1);
        checkOutput({tag, "_lines_released"}, {30'd0, clkOe, datOe}, 32'd0);
        waitNeg(5);
    endtask

    typedef struct {
        string      tag;
        logic [7:0] data;
        int         mode;
        logic [9:0] expFrame;
        logic       expAck;
        logic       expErr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [9:0] bits;
        bit ab;
        int a0;
        int d0;
        int n;
        logic [7:0] rd;
        int rm;

        vecs[0] = '{"ed_ack",   8'hED, 0, 10'h3ED, 1'b1, 1'b0};
        vecs[1] = '{"x01_ack",  8'h01, 0, 10'h201, 1'b1, 1'b0};
        vecs[2] = '{"x00_ack",  8'h00, 0, 10'h300, 1'b1, 1'b0};
        vecs[3] = '{"xff_ack",  8'hFF, 0, 10'h3FF, 1'b1, 1'b0};
        vecs[4] = '{"x55_nack", 8'h55, 1, 10'h355, 1'b0, 1'b1};
        vecs[5] = '{"silent",   8'hA3, 2, 10'h000, 1'b0, 1'b1};

        bus.i_data = 8'h00;
        bus.i_valid = 1'b0;
        waitNeg(5);
        rst = 1'b0;
        waitNeg(1);
        checkOutput("rst_ready", 32'(bus.o_ready), 32'd1);
        checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("rst_done", 32'(bus.o_done), 32'd0);
        checkOutput("rst_ack_ok", 32'(bus.o_ack_ok), 32'd0);
        checkOutput("rst_error", 32'(bus.o_error), 32'd0);
        checkOutput("rst_oe", {30'd0, clkOe, datOe}, 32'd0);

        for (int i = 0; i < 6; i++)
            applyStimulus(vecs[i].tag, vecs[i].data, vecs[i].mode, 0,
                          vecs[i].expFrame, vecs[i].expAck, vecs[i].expErr);

        applyStimulus("glitch", 8'hC6, 0, 3, frameOf(8'hC6), 1'b1, 1'b0);

        // Valid held high across a whole transfer: second accept only once the first has finished.
        a0 = acceptCnt;
        d0 = doneCnt;
        @(negedge clk);
        bus.i_data = 8'h3C;
        bus.i_valid = 1'b1;
        @(negedge clk);
        runDevice("held1", 1'b1, 0, 0, bits, ab);
        checkOutput("held1_frame", 32'(bits), 32'(frameOf(8'h3C)));
        n = 0;
        while (doneCnt == d0 && n < XTO) begin
            @(negedge clk);
            n++;
        end
        checkOutput("held1_accepts_at_done", 32'(acceptAtDone - a0), 32'd1);
        waitNeg(2);
        checkOutput("held2_reaccepted", 32'(acceptCnt - a0), 32'd2);
        bus.i_valid = 1'b0;
        runDevice("held2", 1'b1, 0, 0, bits, ab);
        checkOutput("held2_frame", 32'(bits), 32'(frameOf(8'h3C)));
        n = 0;
        while (doneCnt - d0 < 2 && n < XTO) begin
            @(negedge clk);
            n++;
        end
        checkOutput("held2_done_count", 32'(doneCnt - d0), 32'd2);
        checkOutput("held2_accepts_total", 32'(acceptCnt - a0), 32'd2);
        waitNeg(5);

        // Reset pulled in the middle of the data bits.
        @(negedge clk);
        bus.i_data = 8'h5A;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        runDevice("abort", 1'b1, 0, 5, bits, ab);
        checkOutput("abort_taken", 32'(ab), 32'd1);

        for (int i = 0; i < 8; i++) begin
            rd = 8'($urandom_range(0, 255));
            rm = int'($urandom_range(0, 1));
            applyStimulus($sformatf("rand%0d", i), rd, rm, 0, frameOf(rd), (rm == 0), (rm == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
